// File: rtl/lsu_unit.sv
// lsu_unit: multi-cycle load/store unit that splits byte/half/word accesses
// (including misaligned ones) into one or two aligned word transactions on a
// req/gnt/rvalid memory port, stalling the core until the access completes.
module lsu_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lsu_valid,
  input  logic        lsu_we,
  input  logic [1:0]  lsu_size,
  input  logic        lsu_unsigned,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_stall,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NBE  = XLEN / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ0  = 3'd1,
    WAIT0 = 3'd2,
    REQ1  = 3'd3,
    WAIT1 = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t            state;
  logic [1:0]        off_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic              we_q;
  logic              split_q;
  logic [NBE-1:0]    be_hi_q;
  logic [XLEN-1:0]   wdata_hi_q;
  logic [XLEN-1:0]   rdata0_q;

  logic [NBE-1:0]    mask_c;
  logic [2*NBE-1:0]  be_c;
  logic [2*XLEN-1:0] wdata_sh_c;
  logic [2*XLEN-1:0] ld_word_c;
  logic [XLEN-1:0]   ld_shift_c;
  logic [XLEN-1:0]   ld_ext_c;

  // Stall the core for as long as an access is pending and not yet done.
  assign lsu_stall = lsu_valid & (state != DONE);

  // Lane placement of the incoming request across two consecutive words.
  always_comb begin
    case (lsu_size)
      2'b00:   mask_c = 4'b0001;
      2'b01:   mask_c = 4'b0011;
      default: mask_c = 4'b1111;
    endcase
    be_c       = {4'b0000, mask_c} << lsu_addr[1:0];
    wdata_sh_c = {32'd0, lsu_wdata} << {lsu_addr[1:0], 3'b000};
  end

  // Load result: realign the captured word(s), truncate to size, extend.
  always_comb begin
    ld_word_c  = (state == WAIT1) ? {mem_rdata, rdata0_q} : {32'd0, mem_rdata};
    ld_shift_c = XLEN'(ld_word_c >> {off_q, 3'b000});
    case (size_q)
      2'b00:   ld_ext_c = uns_q ? {24'd0, ld_shift_c[7:0]}
                                : {{24{ld_shift_c[7]}}, ld_shift_c[7:0]};
      2'b01:   ld_ext_c = uns_q ? {16'd0, ld_shift_c[15:0]}
                                : {{16{ld_shift_c[15]}}, ld_shift_c[15:0]};
      default: ld_ext_c = ld_shift_c;
    endcase
  end

  // Access sequencer with registered memory-port and completion outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      off_q      <= 2'b00;
      size_q     <= 2'b00;
      uns_q      <= 1'b0;
      we_q       <= 1'b0;
      split_q    <= 1'b0;
      be_hi_q    <= '0;
      wdata_hi_q <= '0;
      rdata0_q   <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      lsu_done   <= 1'b0;
      lsu_rdata  <= '0;
    end else begin
      lsu_done <= 1'b0;
      case (state)
        IDLE: begin
          if (lsu_valid) begin
            off_q      <= lsu_addr[1:0];
            size_q     <= lsu_size;
            uns_q      <= lsu_unsigned;
            we_q       <= lsu_we;
            split_q    <= |be_c[7:4];
            be_hi_q    <= be_c[7:4];
            wdata_hi_q <= wdata_sh_c[63:32];
            mem_req    <= 1'b1;
            mem_we     <= lsu_we;
            mem_addr   <= {lsu_addr[31:2], 2'b00};
            mem_be     <= be_c[3:0];
            mem_wdata  <= wdata_sh_c[31:0];
            state      <= REQ0;
          end
        end
        REQ0: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT0;
          end
        end
        WAIT0: begin
          if (mem_rvalid) begin
            rdata0_q <= mem_rdata;
            if (split_q) begin
              mem_req   <= 1'b1;
              mem_addr  <= mem_addr + 32'd4;
              mem_be    <= be_hi_q;
              mem_wdata <= wdata_hi_q;
              state     <= REQ1;
            end else begin
              lsu_done <= 1'b1;
              if (!we_q) lsu_rdata <= ld_ext_c;
              state    <= DONE;
            end
          end
        end
        REQ1: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= WAIT1;
          end
        end
        WAIT1: begin
          if (mem_rvalid) begin
            lsu_done <= 1'b1;
            if (!we_q) lsu_rdata <= ld_ext_c;
            state    <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
